// File: rtl/fetch_queue_pkg.sv
// Shared types and widths for the fetch stage and its neighbours.
package fetch_queue_pkg;
  localparam int PC_W          = 16;
  localparam int INSTR_W       = 32;
  localparam int FETCH_ENTRY_W = PC_W + INSTR_W;

  typedef enum logic {RUN, BUBBLE} fq_state_e;
endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH x W synchronous FIFO with a registered head that holds its last value when empty.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = FETCH_ENTRY_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [W-1:0]                 wdata,
  output logic                         head_valid,
  output logic [W-1:0]                 head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     head_q, head_d;

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (pop) rd_d = rd_q + PTR_W'(1);
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
      // Next head may be the word being written this cycle (empty, or last entry popped).
      if (cnt_d != '0) head_d = (push && (wr_q == rd_d)) ? wdata : mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  assign head_valid = (cnt_q != '0);
  assign head_data  = head_q;
  assign count      = cnt_q;
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: owns the PC, buffers {pc, instr} for decode, handles redirect and flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH           = 4,
  parameter logic [PC_W-1:0] RESET_PC        = 16'h0000,
  parameter int              REDIRECT_BUBBLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]         imem_data,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic                       flush_pipeline,
  input  logic                       dec_ready,
  output logic                       out_valid,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int              CNT_W    = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [1:0]       BUB_INIT = 2'(REDIRECT_BUBBLE);

  fq_state_e          state_q, state_d;
  logic [1:0]         bub_q, bub_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               push, pop, clear;
  logic [FETCH_ENTRY_W-1:0] head;

  // Redirect wins over flush; both discard the queue and block push/pop.
  assign clear = redirect_valid | flush_pipeline;
  assign pop   = out_valid & dec_ready & ~clear;
  assign push  = (state_q == RUN) & ~clear & ((occupancy < FULL) | pop);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    bub_d   = bub_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (REDIRECT_BUBBLE > 0) begin
        state_d = BUBBLE;
        bub_d   = BUB_INIT;
      end
    end else begin
      if (push) pc_d = pc_q + PC_W'(1);
      if (state_q == BUBBLE) begin
        if (bub_q == 2'd1) begin
          state_d = RUN;
          bub_d   = '0;
        end else begin
          bub_d = bub_q - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      bub_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  fetch_queue_fifo #(.DEPTH(DEPTH), .W(FETCH_ENTRY_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .wdata     ({pc_q, imem_data}),
    .head_valid(out_valid),
    .head_data (head),
    .count     (occupancy)
  );

  assign imem_addr = pc_q;
  assign out_pc    = head[FETCH_ENTRY_W-1:INSTR_W];
  assign out_instr = head[INSTR_W-1:0];
endmodule
